// File: rtl/dmem_pkg.sv
// dmem_pkg: shared load/store encodings, enable bit positions and store byte-lane helper
package dmem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;
  localparam int READ_EN_BIT  = 3;
  localparam int WRITE_EN_BIT = 2;
  function automatic logic [3:0] store_lanes(input logic [1:0] st, input logic [1:0] off);
    return st == ST_B ? 4'b0001 << off :
           st == ST_H ? (off[1] ? 4'b1100 : 4'b0011) :
           st == ST_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/data_memory_load_extend.sv
// load_extend: picks the byte/halfword of an aligned word by funct3 and offset, then sign/zero extends (word, off, funct3 -> data)
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  assign shifted = word >> {off, 3'b000};
  assign b = shifted[7:0];
  assign h = off[1] ? word[31:16] : word[15:0];
  always_comb begin
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LW  ? word :
           funct3 == F3_LBU ? {24'h0, b} :
           funct3 == F3_LHU ? {16'h0, h} : 32'h0;
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian RV32 data memory with optional access latency (clock, reset, read, write, address, writedata -> readdata, busywait)
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [CW-1:0] cnt;
  logic [AW-3:0] widx;
  logic [31:0]   word, lane, ext;
  logic [3:0]    be;
  logic          commit, unused_addr;
  assign unused_addr = ^address[31:AW];
  assign widx = address[AW-1:2];
  assign word = {mem[{widx, 2'd3}], mem[{widx, 2'd2}], mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
  assign be = store_lanes(write[1:0], address[1:0]);
  assign lane = write[1:0] == ST_B ? {4{writedata[7:0]}} :
                write[1:0] == ST_H ? {2{writedata[15:0]}} : writedata;
  // With LATENCY=0 the counter never leaves 0, so the compare is always equal and busywait stays low.
  assign busywait = !reset && (read[READ_EN_BIT] || write[WRITE_EN_BIT]) && cnt != CW'(LATENCY);
  assign commit = write[WRITE_EN_BIT] && !busywait;
  assign readdata = read[READ_EN_BIT] && !reset ? ext : 32'h0;
  load_extend u_ext (
    .word   (word),
    .off    (address[1:0]),
    .funct3 (read[2:0]),
    .data   (ext)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= busywait ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else if (commit) begin
      for (int j = 0; j < 4; j++) if (be[j]) mem[{widx, 2'(j)}] <= lane[8*j +: 8];
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory at LATENCY 0 and 2 against a byte-array reference model
module tb_data_memory;
  import dmem_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic        rsta, rstb, bwa, bwb;
  logic [3:0]  ra, rb;
  logic [2:0]  wa, wb;
  logic [31:0] aa, ab, da, db, rda, rdb;
  data_memory #(.DEPTH_BYTES(1024), .LATENCY(0)) dut_a (
    .clock(clk), .reset(rsta), .read(ra), .write(wa), .address(aa),
    .writedata(da), .readdata(rda), .busywait(bwa));
  data_memory #(.DEPTH_BYTES(1024), .LATENCY(2)) dut_b (
    .clock(clk), .reset(rstb), .read(rb), .write(wb), .address(ab),
    .writedata(db), .readdata(rdb), .busywait(bwb));
  typedef struct {string name; logic [31:0] exp;} exp_t;
  exp_t qa[$], qb[$];
  bit chk_a = 0, chk_b = 0;
  int errors = 0, checks = 0;
  logic [7:0] model [2][1024];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(int d, logic [31:0] addr, logic [2:0] f3);
    int size, a;
    logic [31:0] v = 0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 0;
    size = 1 << f3[1:0];
    a = int'(addr % 1024);
    a = a - a % size;
    for (int k = 0; k < size; k++) v = v | (32'(model[d][a+k]) << (8*k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 1);
    return v;
  endfunction

  function automatic void ref_store(int d, logic [31:0] addr, logic [1:0] f3, logic [31:0] data);
    int size, a;
    if (f3 == 2'b11) return;
    size = 1 << f3;
    a = int'(addr % 1024);
    a = a - a % size;
    for (int k = 0; k < size; k++) model[d][a+k] = data[8*k +: 8];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_a) begin
      if (qa.size() == 0) begin errors++; checks++; $display("FAIL scoreboard_a: no expected entry"); end
      else begin e = qa.pop_front(); check(e.name, rda, e.exp); end
      chk_a = 0;
    end
    if (chk_b && !bwb) begin
      if (qb.size() == 0) begin errors++; checks++; $display("FAIL scoreboard_b: no expected entry"); end
      else begin e = qb.pop_front(); check(e.name, rdb, e.exp); end
      chk_b = 0;
    end
  end

  task automatic op_a(logic [3:0] r, logic [2:0] w, logic [31:0] a, logic [31:0] d,
                      string name, logic [31:0] exp, bit use_model);
    logic [31:0] e;
    @(posedge clk); #1;
    ra = r; wa = w; aa = a; da = d;
    e = use_model ? (r[3] ? ref_load(0, a, r[2:0]) : 32'h0) : exp;
    qa.push_back('{name, e});
    chk_a = 1;
    if (w[2]) ref_store(0, a, w[1:0], d);
    @(posedge clk); #1;
    ra = 0; wa = 0;
  endtask

  task automatic op_b(logic [3:0] r, logic [2:0] w, logic [31:0] a, logic [31:0] d,
                      string name, logic [31:0] exp, bit use_model);
    logic [31:0] e;
    int n = 0;
    @(posedge clk); #1;
    rb = r; wb = w; ab = a; db = d;
    e = use_model ? (r[3] ? ref_load(1, a, r[2:0]) : 32'h0) : exp;
    qb.push_back('{name, e});
    chk_b = 1;
    if (w[2]) ref_store(1, a, w[1:0], d);
    forever begin
      @(negedge clk);
      if (!bwb || n > 20) break;
      n++;
    end
    check({name, "_stall"}, 32'(n), 32'd2);
    @(posedge clk); #1;
    rb = 0; wb = 0;
    check({name, "_popped"}, 32'(chk_b), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    logic [2:0] w;
    logic [31:0] a;
    rsta = 1; rstb = 1;
    ra = 0; wa = 0; aa = 0; da = 0;
    rb = 0; wb = 0; ab = 0; db = 0;
    for (int i = 0; i < 1024; i++) begin model[0][i] = 0; model[1][i] = 0; end
    repeat (2) @(posedge clk);
    #1 rsta = 0; rstb = 0;
    @(negedge clk);
    check("reset_busy_a", 32'(bwa), 0);
    check("reset_busy_b", 32'(bwb), 0);
    op_a(4'b1010, 3'b000, 32'h10, 0, "reset_lw", 32'h0, 0);
    op_a(4'b0000, 3'b110, 32'h10, 32'hAABBCCDD, "sw_noread", 32'h0, 0);
    op_a(4'b1010, 3'b000, 32'h10, 0, "lw_10", 32'hAABBCCDD, 0);
    op_a(4'b1000, 3'b000, 32'h10, 0, "lb_10", 32'hFFFFFFDD, 0);
    op_a(4'b1100, 3'b000, 32'h10, 0, "lbu_10", 32'h000000DD, 0);
    op_a(4'b1001, 3'b000, 32'h10, 0, "lh_10", 32'hFFFFCCDD, 0);
    op_a(4'b1101, 3'b000, 32'h10, 0, "lhu_10", 32'h0000CCDD, 0);
    op_a(4'b1000, 3'b000, 32'h13, 0, "lb_13", 32'hFFFFFFAA, 0);
    op_a(4'b1010, 3'b000, 32'h13, 0, "lw_13_aligned", 32'hAABBCCDD, 0);
    op_a(4'b1011, 3'b000, 32'h10, 0, "lf3_011_zero", 32'h0, 0);
    op_a(4'b0000, 3'b100, 32'h20, 32'h0000007F, "sb_20", 32'h0, 0);
    op_a(4'b1000, 3'b000, 32'h20, 0, "lb_20", 32'h0000007F, 0);
    op_a(4'b1010, 3'b000, 32'h20, 0, "lw_20", 32'h0000007F, 0);
    op_a(4'b0000, 3'b101, 32'h30, 32'h00007FFF, "sh_30", 32'h0, 0);
    op_a(4'b1001, 3'b000, 32'h30, 0, "lh_30", 32'h00007FFF, 0);
    op_a(4'b1101, 3'b000, 32'h30, 0, "lhu_30", 32'h00007FFF, 0);
    op_a(4'b0000, 3'b101, 32'h32, 32'h00008000, "sh_32", 32'h0, 0);
    op_a(4'b1010, 3'b000, 32'h30, 0, "lw_30", 32'h80007FFF, 0);
    op_a(4'b1001, 3'b000, 32'h32, 0, "lh_32", 32'hFFFF8000, 0);
    op_a(4'b1001, 3'b000, 32'h33, 0, "lh_33_aligned", 32'hFFFF8000, 0);
    op_a(4'b0000, 3'b111, 32'h10, 32'h55555555, "st_f3_11", 32'h0, 0);
    op_a(4'b1010, 3'b000, 32'h10, 0, "lw_after_f3_11", 32'hAABBCCDD, 0);
    op_a(4'b1010, 3'b110, 32'h10, 32'h11223344, "same_cycle_old", 32'hAABBCCDD, 0);
    op_a(4'b1010, 3'b000, 32'h10, 0, "same_cycle_new", 32'h11223344, 0);
    op_a(4'b0000, 3'b110, 32'h1450, 32'h0BADF00D, "sw_wrap", 32'h0, 0);
    op_a(4'b1010, 3'b000, 32'h50, 0, "lw_wrap", 32'h0BADF00D, 0);
    for (int i = 0; i < 300; i++) begin
      r = 4'($urandom);
      w = 3'($urandom);
      a = ($urandom & 32'hFFFF_FC00) | (i % 5 == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 63));
      op_a(r, w, a, $urandom, "rand_a", 0, 1);
    end
    op_b(4'b0000, 3'b110, 32'h8, 32'hCAFEF00D, "b_sw_8", 32'h0, 0);
    op_b(4'b1010, 3'b000, 32'h8, 0, "b_lw_8", 32'hCAFEF00D, 0);
    op_b(4'b1000, 3'b000, 32'hB, 0, "b_lb_b", 32'hFFFFFFCA, 0);
    for (int i = 0; i < 25; i++) begin
      r = 4'($urandom);
      w = 3'($urandom);
      if (!r[3] && !w[2]) r[3] = 1;
      op_b(r, w, $urandom_range(0, 31), $urandom, "rand_b", 0, 1);
    end
    op_b(4'b0000, 3'b110, 32'h40, 32'h12345678, "b_sw_40", 32'h0, 0);
    @(posedge clk); #1;
    wb = 3'b110; ab = 32'h40; db = 32'hDEADBEEF;
    @(negedge clk);
    check("b_held_busy", 32'(bwb), 1);
    rstb = 1;
    #1 check("b_reset_busy", 32'(bwb), 0);
    @(posedge clk); #1;
    wb = 0;
    rstb = 0;
    for (int i = 0; i < 1024; i++) model[1][i] = 0;
    op_b(4'b1010, 3'b000, 32'h40, 0, "b_lw_40_after_reset", 32'h0, 0);
    op_b(4'b1010, 3'b000, 32'h8, 0, "b_lw_8_after_reset", 32'h0, 0);
    repeat (2) @(posedge clk);
    check("queue_a_drained", 32'(qa.size()), 0);
    check("queue_b_drained", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
